// File: rtl/alu_operand_stager_if.sv
// alu_operand_stager_if
//    Bus between the operand source, the operand stager and the downstream
//    ALU stage.
//    Signals:
//       din       shared operand bus (source -> stager)
//       op_in     opcode, sampled with the second load (source -> stager)
//       load      single-cycle capture strobe (source -> stager)
//       out_ready downstream accepts the operands (ALU -> stager)
//       out_valid A, B and op are complete and stable (stager -> ALU)
//       a_out     operand A (stager -> ALU)
//       b_out     operand B (stager -> ALU)
//       op_out    opcode (stager -> ALU)
//    Modports: master = environment/driver side, slave = stager side.
interface alu_operand_stager_if #(
   parameter int WIDTH = 4,
   parameter int OP_W  = 2
);
   logic [WIDTH-1:0] din;
   logic [OP_W-1:0]  op_in;
   logic             load;
   logic             out_ready;
   logic             out_valid;
   logic [WIDTH-1:0] a_out;
   logic [WIDTH-1:0] b_out;
   logic [OP_W-1:0]  op_out;

   modport master (
      output din, op_in, load, out_ready,
      input  out_valid, a_out, b_out, op_out
   );

   modport slave (
      input  din, op_in, load, out_ready,
      output out_valid, a_out, b_out, op_out
   );
endinterface

// File: rtl/alu_operand_stager.sv
// alu_operand_stager
//    Collects operand A, operand B and an opcode from a shared bus using
//    single-cycle load strobes, holds them stable and offers them to the ALU
//    through a valid/ready handshake. Completed transfers are counted.
//    Ports:
//       clk       system clock, rising edge
//       rst_n     asynchronous active-low reset
//       clr       synchronous clear back to EMPTY (issue_cnt kept)
//       bus       alu_operand_stager_if.slave (din, op_in, load, out_ready,
//                 out_valid, a_out, b_out, op_out)
//       have_a    operand A captured, B pending
//       issue_cnt completed handshakes, wraps modulo 2^CNT_W
//    Optional feature (macro ALU_STAGER_LOADTHRU_EN): a load coinciding with
//    the handshake in FULL captures the next A directly and moves to HAVE_A.
//    Without it that load is dropped and the stager returns to EMPTY.
//
//    state  | meaning
//    EMPTY  | no operand held
//    HAVE_A | operand A held, waiting for B and opcode
//    FULL   | A, B, op held; out_valid high until handshake
module alu_operand_stager #(
   parameter int WIDTH = 4,
   parameter int OP_W  = 2,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   alu_operand_stager_if.slave   bus,
   output logic                  have_a,
   output logic [CNT_W-1:0]      issue_cnt
);

   // Encoding chosen so out_valid and have_a are each a single state flop.
   typedef enum logic [1:0] {
      EMPTY  = 2'b00,
      HAVE_A = 2'b01,
      FULL   = 2'b10
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_nxt, b_nxt;
   logic [OP_W-1:0]  op_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             xfer;

   assign xfer          = (state == FULL) && bus.out_ready;
   assign bus.out_valid = state[1];
   assign have_a        = state[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY:   if (bus.load) state_nxt = HAVE_A;
            HAVE_A:  if (bus.load) state_nxt = FULL;
            FULL: begin
               if (bus.out_ready) begin
`ifdef ALU_STAGER_LOADTHRU_EN
                  state_nxt = bus.load ? HAVE_A : EMPTY;
`else
                  state_nxt = EMPTY;
`endif
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_comb begin
      a_nxt   = bus.a_out;
      b_nxt   = bus.b_out;
      op_nxt  = bus.op_out;
      cnt_nxt = issue_cnt;
      if (clr) begin
         a_nxt  = '0;
         b_nxt  = '0;
         op_nxt = '0;
      end else begin
         if ((state == EMPTY) && bus.load) a_nxt = bus.din;
         if ((state == HAVE_A) && bus.load) begin
            b_nxt  = bus.din;
            op_nxt = bus.op_in;
         end
         if (xfer) begin
            // Operands are left in place after the transfer for debug visibility.
            cnt_nxt = issue_cnt + 1'b1;
`ifdef ALU_STAGER_LOADTHRU_EN
            if (bus.load) a_nxt = bus.din;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.a_out  <= '0;
         bus.b_out  <= '0;
         bus.op_out <= '0;
         issue_cnt  <= '0;
      end else begin
         bus.a_out  <= a_nxt;
         bus.b_out  <= b_nxt;
         bus.op_out <= op_nxt;
         issue_cnt  <= cnt_nxt;
      end
   end

endmodule
